bht_upd_sched: RTL and testbench
================================

Name: bht_upd_sched

Overview:
Update scheduler for the branch history table. Two branch-resolve requesters share the table's single update port.
- Resolve results are arbitrated round-robin into a small in-order queue.
- The queue drains one update per cycle onto the table's PC/TAKE/WE update inputs.
- The block reports pending-update hazards to the predict stage and supports pipeline flush.

Parameters:
addr_width, 32, width of PC fields
num_entries, 4, BHT entry count; index = low clog2(num_entries) PC bits
queue_depth, 4, update queue depth; power of 2, >= 2

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
REQ0_VALID  in  1  requester 0 has a resolved branch
REQ0_PC  in  addr_width  requester 0 branch PC
REQ0_TAKE  in  1  requester 0 outcome (1 = taken)
REQ0_READY  out  1  requester 0 accepted this cycle
REQ1_VALID  in  1  requester 1 has a resolved branch
REQ1_PC  in  addr_width  requester 1 branch PC
REQ1_TAKE  in  1  requester 1 outcome
REQ1_READY  out  1  requester 1 accepted this cycle
HOLD  in  1  pause draining; queue keeps accepting
FLUSH  in  1  discard all queued updates
BHT_PC  out  addr_width  update PC to BHT
BHT_TAKE  out  1  update outcome to BHT
BHT_WE  out  1  update write enable to BHT
LOOKUP_PC  in  addr_width  PC being predicted this cycle
LOOKUP_HIT  out  1  queued update pending for LOOKUP_PC's index
COUNT  out  clog2(queue_depth)+1  occupied queue entries

Behaviour:
- Reset (asynchronous, RST=1): queue empty, head/tail pointers 0, COUNT=0, round-robin pointer=0. All outputs 0 (BHT_PC=0, BHT_TAKE=0, BHT_WE=0, READY=0, LOOKUP_HIT=0). Reset asserted mid-operation discards all queued entries immediately.
- Transfer rule: a transfer occurs on a rising edge when REQn_VALID & REQn_READY. At most one enqueue per cycle.
- Arbitration:
  - Only one valid requester: it is granted.
  - Both valid: the requester named by the RR pointer is granted.
  - After any accepted transfer, the RR pointer is set to the other requester. With no transfer, the pointer holds.
- READY:
  - REQn_READY = grant_n & (COUNT < queue_depth) & !FLUSH.
  - The space check uses registered COUNT; no credit is taken for a same-cycle dequeue. READY has no path from HOLD.
  - The non-granted requester sees READY=0 and must hold VALID and data.
- Dequeue:
  - BHT_WE = (COUNT != 0) & !HOLD & !FLUSH. This is combinational from registered state plus HOLD/FLUSH.
  - BHT_PC and BHT_TAKE always show the head entry, or 0 when empty.
  - Head is popped on any edge where BHT_WE=1. The BHT samples the same edge, so latency from acceptance to BHT_WE is at least 1 cycle.
- Ordering: strict FIFO. Updates reach the BHT in acceptance order, including repeated updates to the same index.
- Simultaneous enqueue and dequeue: COUNT unchanged and both pointers advance. This is legal when full: the pop frees a slot but no enqueue occurs that cycle, since READY was 0.
- Pointer wrap: pointers are clog2(queue_depth) bits and wrap modulo queue_depth. COUNT distinguishes full from empty.
- FLUSH (synchronous, takes priority over enqueue and dequeue):
  - At the edge: COUNT←0, pointers←0, RR pointer←0.
  - While FLUSH=1: READY=0 and BHT_WE=0.
- LOOKUP_HIT: combinational OR over occupied entries of (entry.PC[idx] == LOOKUP_PC[idx]), where idx = clog2(num_entries)-1:0.
  - Covers registered entries only. The entry being enqueued this cycle is excluded.
  - Cleared in the same cycle as FLUSH.
- Never: BHT_WE=1 when COUNT=0; COUNT > queue_depth.

Test Plan:
- Reset then idle: RST pulse, no VALID -> all outputs 0, COUNT=0. Reassert RST with 3 entries queued -> COUNT=0 and BHT_WE=0 immediately, without waiting for a clock edge.
- Single update: REQ0 PC=0x104, TAKE=1 for 1 cycle -> next cycle BHT_WE=1, BHT_PC=0x104, BHT_TAKE=1. Following cycle BHT_WE=0, COUNT=0.
- Contention: both VALID held 4 cycles with HOLD=1 -> acceptance order REQ0, REQ1, REQ0, REQ1. COUNT=4, both READY=0 when full. Release HOLD -> 4 BHT_WE cycles in the same order.
- Full with simultaneous pop: COUNT=4, HOLD=0, REQ1 valid -> cycle 1 pops with REQ1_READY=0, COUNT=3. Cycle 2 enqueue and pop together, COUNT stays 3.
- Hazard: queue holds PC=0x10 and 0x23 (num_entries=4) -> LOOKUP_PC=0x40 gives HIT=1 (index 0). LOOKUP_PC=0x23 gives HIT=1. LOOKUP_PC=0x21 gives HIT=0.
- Flush mid-drain: COUNT=3, assert FLUSH 1 cycle with REQ0 valid -> REQ0_READY=0 and BHT_WE=0 that cycle. Next cycle COUNT=0, LOOKUP_HIT=0, and a subsequent REQ0 is granted first.

Source files
------------

// File: rtl/bht_upd_sched.sv
// bht_upd_sched: the update scheduler for the branch history table.
// Two branch-resolve requesters share the table's single update port. Resolved
// branches go through a round-robin arbiter into a small in-order queue. The
// queue drains one update per cycle onto the table's update port. The block also
// reports pending-update hazards to the predict stage and supports pipeline flush.
//
// Ports:
//   CLK, RST                       clock (rising edge), async active-high reset
//   REQn_VALID/PC/TAKE, REQn_READY resolve requesters 0 and 1 (valid/ready)
//   HOLD                           pause draining; the queue keeps accepting
//   FLUSH                          discard all queued updates (synchronous)
//   BHT_PC/TAKE/WE                 head-of-queue update driven to the BHT
//   LOOKUP_PC, LOOKUP_HIT          hazard probe for the predict stage
//   COUNT                          number of occupied queue entries
module bht_upd_sched #(
    parameter int addr_width  = 32,
    parameter int num_entries = 4,
    parameter int queue_depth = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          REQ0_VALID,
    input  logic [addr_width-1:0]         REQ0_PC,
    input  logic                          REQ0_TAKE,
    output logic                          REQ0_READY,
    input  logic                          REQ1_VALID,
    input  logic [addr_width-1:0]         REQ1_PC,
    input  logic                          REQ1_TAKE,
    output logic                          REQ1_READY,
    input  logic                          HOLD,
    input  logic                          FLUSH,
    output logic [addr_width-1:0]         BHT_PC,
    output logic                          BHT_TAKE,
    output logic                          BHT_WE,
    input  logic [addr_width-1:0]         LOOKUP_PC,
    output logic                          LOOKUP_HIT,
    output logic [$clog2(queue_depth):0]  COUNT
);

    localparam int PW = $clog2(queue_depth);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(num_entries);
    localparam logic [CW-1:0] DEPTH_C = CW'(queue_depth);

    logic [addr_width-1:0] r_pc   [queue_depth];
    logic                  r_take [queue_depth];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_rr;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_space;
    logic                  w_enq0;
    logic                  w_enq1;
    logic                  w_enq;
    logic [addr_width-1:0] w_enq_pc;
    logic                  w_enq_take;
    logic                  w_nonempty;
    logic                  w_hit;
    logic [PW-1:0]         w_off;

    // Round-robin grant: a lone requester always wins, and a tie goes to r_rr.
    always_comb begin
        w_gnt0 = REQ0_VALID & (~REQ1_VALID | ~r_rr);
        w_gnt1 = REQ1_VALID & (~REQ0_VALID |  r_rr);
    end

    // The space check uses the registered occupancy only. A pop in the same
    // cycle does not count toward free space, so READY never depends on HOLD.
    assign w_space    = (r_count < DEPTH_C);
    assign REQ0_READY = w_gnt0 & w_space & ~FLUSH & ~RST;
    assign REQ1_READY = w_gnt1 & w_space & ~FLUSH & ~RST;

    assign w_enq0     = REQ0_VALID & REQ0_READY;
    assign w_enq1     = REQ1_VALID & REQ1_READY;
    assign w_enq      = w_enq0 | w_enq1;
    assign w_enq_pc   = w_enq1 ? REQ1_PC   : REQ0_PC;
    assign w_enq_take = w_enq1 ? REQ1_TAKE : REQ0_TAKE;

    assign w_nonempty = (r_count != '0);
    assign BHT_WE     = w_nonempty & ~HOLD & ~FLUSH;
    assign BHT_PC     = w_nonempty ? r_pc[r_head]   : '0;
    assign BHT_TAKE   = w_nonempty ? r_take[r_head] : 1'b0;
    assign COUNT      = r_count;

    // A slot is occupied when its distance from the head is below the count.
    // The entry being written this cycle is not in storage yet, so the hazard
    // probe does not see it.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int i = 0; i < queue_depth; i++) begin
            w_off = PW'(i) - r_head;
            if (({1'b0, w_off} < r_count) &&
                (r_pc[i][IW-1:0] == LOOKUP_PC[IW-1:0]))
                w_hit = 1'b1;
        end
    end
    assign LOOKUP_HIT = w_hit & ~FLUSH;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < queue_depth; i++) begin
                r_pc[i]   <= '0;
                r_take[i] <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rr    <= 1'b0;
        end else if (FLUSH) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_rr    <= 1'b0;
        end else begin
            if (w_enq) begin
                r_pc[r_tail]   <= w_enq_pc;
                r_take[r_tail] <= w_enq_take;
                r_tail         <= r_tail + PW'(1);
                // Point at the requester that did not just transfer.
                r_rr           <= w_enq0;
            end
            if (BHT_WE)
                r_head <= r_head + PW'(1);
            case ({w_enq, BHT_WE})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bht_upd_sched.sv
module tb_bht_upd_sched;

    localparam int DEPTH = 4;
    localparam int NENT  = 4;

    logic        CLK, RST;
    logic        v0, t0, v1, t1, hold, flush;
    logic [31:0] pc0, pc1, lk;
    logic        r0o, r1o, bht_take, bht_we, hit;
    logic [31:0] bht_pc;
    logic [2:0]  cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bht_upd_sched #(.addr_width(32), .num_entries(NENT), .queue_depth(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(v0), .REQ0_PC(pc0), .REQ0_TAKE(t0), .REQ0_READY(r0o),
        .REQ1_VALID(v1), .REQ1_PC(pc1), .REQ1_TAKE(t1), .REQ1_READY(r1o),
        .HOLD(hold), .FLUSH(flush),
        .BHT_PC(bht_pc), .BHT_TAKE(bht_take), .BHT_WE(bht_we),
        .LOOKUP_PC(lk), .LOOKUP_HIT(hit), .COUNT(cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a plain queue of pending updates plus the tie-break owner.
    typedef struct packed { logic [31:0] pc; logic take; } ent_t;
    ent_t mq[$];
    int   m_rr;

    logic        e_r0, e_r1, e_we, e_take, e_hit;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;

    function automatic void calc_exp();
        int g;
        if (v0 && v1)  g = m_rr;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
        else           g = -1;
        e_r0   = (g == 0) && (mq.size() < DEPTH) && !flush;
        e_r1   = (g == 1) && (mq.size() < DEPTH) && !flush;
        e_we   = (mq.size() != 0) && !hold && !flush;
        e_pc   = (mq.size() != 0) ? mq[0].pc   : 32'h0;
        e_take = (mq.size() != 0) ? mq[0].take : 1'b0;
        e_cnt  = 3'(mq.size());
        e_hit  = 1'b0;
        if (!flush)
            foreach (mq[i])
                if ((mq[i].pc % NENT) == (lk % NENT)) e_hit = 1'b1;
    endfunction

    task automatic model_edge();
        if (flush) begin
            mq.delete();
            m_rr = 0;
        end else begin
            if (e_we) void'(mq.pop_front());
            if (e_r0 && v0) begin
                mq.push_back('{pc: pc0, take: t0});
                m_rr = 1;
            end else if (e_r1 && v1) begin
                mq.push_back('{pc: pc1, take: t1});
                m_rr = 0;
            end
        end
    endtask

    task automatic settle();
        #1;
        calc_exp();
    endtask

    task automatic adv();
        calc_exp();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic idle_in();
        v0 = 0; v1 = 0; t0 = 0; t1 = 0; pc0 = 0; pc1 = 0;
        hold = 0; flush = 0; lk = 0;
    endtask

    task automatic test_reset();
        RST = 1; idle_in(); v0 = 1; v1 = 1; pc0 = 32'h55;
        #2;
        n_tests++; if ({r0o, r1o, bht_we, bht_take, hit} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b exp 00000", {r0o, r1o, bht_we, bht_take, hit}); end
        n_tests++; if (bht_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h exp 0", bht_pc); end
        n_tests++; if (cnt !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d exp 0", cnt); end
        @(negedge CLK);
        idle_in(); RST = 0; mq.delete(); m_rr = 0;
        for (int k = 0; k < 2; k++) begin
            settle();
            n_tests++; if ({bht_we, r0o, r1o, cnt} !== 6'b0) begin
                n_fail++; $display("FAIL idle: got we=%b r0=%b r1=%b cnt=%0d exp all 0", bht_we, r0o, r1o, cnt); end
            adv();
        end
    endtask

    task automatic test_single();
        v0 = 1; pc0 = 32'h104; t0 = 1;
        settle();
        n_tests++; if (r0o !== 1'b1 || bht_we !== 1'b0) begin
            n_fail++; $display("FAIL single_accept: got r0=%b we=%b exp r0=1 we=0", r0o, bht_we); end
        adv();
        v0 = 0; pc0 = 0; t0 = 0;
        settle();
        n_tests++; if (bht_we !== 1'b1 || bht_pc !== 32'h104 || bht_take !== 1'b1) begin
            n_fail++; $display("FAIL single_drain: got we=%b pc=%h take=%b exp 1 104 1", bht_we, bht_pc, bht_take); end
        adv();
        settle();
        n_tests++; if (bht_we !== 1'b0 || cnt !== 3'd0) begin
            n_fail++; $display("FAIL single_empty: got we=%b cnt=%0d exp 0 0", bht_we, cnt); end
    endtask

    task automatic test_contention();
        logic [31:0] ep;
        flush = 1; adv(); flush = 0;
        hold = 1; v0 = 1; v1 = 1; t0 = 1; t1 = 0;
        for (int k = 0; k < DEPTH; k++) begin
            pc0 = 32'h200 + 32'(4 * ((k + 1) / 2));
            pc1 = 32'h300 + 32'(4 * (k / 2));
            settle();
            n_tests++; if (r0o !== (k % 2 == 0) || r1o !== (k % 2 == 1)) begin
                n_fail++; $display("FAIL contend_grant%0d: got r0=%b r1=%b exp r0=%b", k, r0o, r1o, (k % 2 == 0)); end
            adv();
        end
        settle();
        n_tests++; if (cnt !== 3'd4 || r0o !== 1'b0 || r1o !== 1'b0) begin
            n_fail++; $display("FAIL contend_full: got cnt=%0d r0=%b r1=%b exp 4 0 0", cnt, r0o, r1o); end
        v0 = 0; v1 = 0; hold = 0;
        for (int j = 0; j < DEPTH; j++) begin
            ep = ((j % 2) == 0 ? 32'h200 : 32'h300) + 32'(4 * (j / 2));
            settle();
            n_tests++; if (bht_we !== 1'b1 || bht_pc !== ep || bht_take !== (j % 2 == 0)) begin
                n_fail++; $display("FAIL contend_order%0d: got we=%b pc=%h take=%b exp pc=%h", j, bht_we, bht_pc, bht_take, ep); end
            adv();
        end
    endtask

    task automatic test_full_pop();
        hold = 1; v0 = 1; t0 = 0;
        for (int k = 0; k < DEPTH; k++) begin
            pc0 = 32'h400 + 32'(4 * k);
            adv();
        end
        v0 = 0; hold = 0; v1 = 1; pc1 = 32'h500; t1 = 1;
        settle();
        n_tests++; if (cnt !== 3'd4 || r1o !== 1'b0 || bht_we !== 1'b1 || bht_pc !== 32'h400) begin
            n_fail++; $display("FAIL fullpop_c1: got cnt=%0d r1=%b we=%b pc=%h exp 4 0 1 400", cnt, r1o, bht_we, bht_pc); end
        adv();
        settle();
        n_tests++; if (cnt !== 3'd3 || r1o !== 1'b1 || bht_we !== 1'b1 || bht_pc !== 32'h404) begin
            n_fail++; $display("FAIL fullpop_c2: got cnt=%0d r1=%b we=%b pc=%h exp 3 1 1 404", cnt, r1o, bht_we, bht_pc); end
        adv();
        v1 = 0;
        settle();
        n_tests++; if (cnt !== 3'd3) begin
            n_fail++; $display("FAIL fullpop_c3: got cnt=%0d exp 3", cnt); end
        for (int k = 0; k < 3; k++) adv();
        settle();
        n_tests++; if (cnt !== 3'd0 || bht_pc !== 32'h0) begin
            n_fail++; $display("FAIL fullpop_drain: got cnt=%0d pc=%h exp 0 0", cnt, bht_pc); end
    endtask

    task automatic test_hazard();
        hold = 1; v0 = 1; pc0 = 32'h10; t0 = 1; lk = 32'h10;
        settle();
        n_tests++; if (hit !== 1'b0) begin
            n_fail++; $display("FAIL hazard_inflight: got %b exp 0", hit); end
        adv();
        pc0 = 32'h23;
        adv();
        v0 = 0;
        lk = 32'h40; settle();
        n_tests++; if (hit !== 1'b1) begin
            n_fail++; $display("FAIL hazard_40: got %b exp 1", hit); end
        lk = 32'h23; settle();
        n_tests++; if (hit !== 1'b1) begin
            n_fail++; $display("FAIL hazard_23: got %b exp 1", hit); end
        lk = 32'h21; settle();
        n_tests++; if (hit !== 1'b0) begin
            n_fail++; $display("FAIL hazard_21: got %b exp 0", hit); end
    endtask

    task automatic test_flush();
        v0 = 1; pc0 = 32'h31; adv();
        hold = 0; v0 = 1; pc0 = 32'h77; flush = 1; lk = 32'h23;
        settle();
        n_tests++; if (cnt !== 3'd3 || r0o !== 1'b0 || bht_we !== 1'b0 || hit !== 1'b0) begin
            n_fail++; $display("FAIL flush_cycle: got cnt=%0d r0=%b we=%b hit=%b exp 3 0 0 0", cnt, r0o, bht_we, hit); end
        adv();
        flush = 0; v1 = 1; pc1 = 32'h88;
        settle();
        n_tests++; if (cnt !== 3'd0 || hit !== 1'b0 || r0o !== 1'b1 || r1o !== 1'b0) begin
            n_fail++; $display("FAIL flush_after: got cnt=%0d hit=%b r0=%b r1=%b exp 0 0 1 0", cnt, hit, r0o, r1o); end
        adv();
        v0 = 0; v1 = 0; adv(); adv();
    endtask

    task automatic test_reset_mid();
        hold = 1; v0 = 1;
        for (int k = 0; k < 3; k++) begin pc0 = 32'h600 + 32'(k); adv(); end
        v0 = 0; hold = 0;
        #2 RST = 1;
        #1;
        n_tests++; if (cnt !== 3'd0 || bht_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got cnt=%0d we=%b exp 0 0", cnt, bht_we); end
        @(negedge CLK);
        RST = 0; mq.delete(); m_rr = 0;
        settle();
        n_tests++; if (cnt !== 3'd0 || bht_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_after: got cnt=%0d pc=%h exp 0 0", cnt, bht_pc); end
    endtask

    task automatic test_random();
        int errs = 0;
        logic acc0, acc1;
        idle_in();
        for (int k = 0; k < 500; k++) begin
            settle();
            n_tests++;
            if (r0o !== e_r0 || r1o !== e_r1 || bht_we !== e_we || bht_pc !== e_pc ||
                bht_take !== e_take || hit !== e_hit || cnt !== e_cnt) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random%0d: got r0=%b r1=%b we=%b pc=%h tk=%b hit=%b cnt=%0d exp %b %b %b %h %b %b %0d",
                             k, r0o, r1o, bht_we, bht_pc, bht_take, hit, cnt,
                             e_r0, e_r1, e_we, e_pc, e_take, e_hit, e_cnt);
            end
            acc0 = e_r0 && v0;
            acc1 = e_r1 && v1;
            adv();
            if (!v0 || acc0) begin
                v0 = ($urandom_range(0, 2) != 0); pc0 = 32'($urandom_range(0, 255)); t0 = 1'($urandom);
            end
            if (!v1 || acc1) begin
                v1 = ($urandom_range(0, 2) != 0); pc1 = 32'($urandom_range(0, 255)); t1 = 1'($urandom);
            end
            hold  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 24) == 0);
            lk    = 32'($urandom_range(0, 255));
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_pop();
        test_hazard();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
